// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants. CORE_RESET_PC is the core-wide boot address,
// so the core and the fetch stage both take it from this one place.
package instr_fetch_pkg;

  localparam int unsigned CORE_RESET_PC    = 0;
  localparam int          IF_ADDRESS_WIDTH = 14;
  localparam int          IF_DATA_WIDTH    = 32;
  localparam int          IF_BUF_DEPTH     = 3;

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-style FIFO for fetched {pc, instr} entries. Entry 0 is always
// the head, so the head data and the empty flag come straight from flops.
module fetch_fifo #(
  parameter  int WIDTH     = 46,
  parameter  int BUF_DEPTH = 3,
  localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic [CW-1:0]    wr_idx;

  // Next-state: flush wins; otherwise pop shifts down, push lands after the last live entry.
  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop && !empty_q) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        cnt_d  = cnt_q - CW'(1);
        wr_idx = cnt_q - CW'(1);
      end
      if (push && (int'(wr_idx) < BUF_DEPTH)) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          if (CW'(i) == wr_idx) mem_d[i] = din;
        end
        cnt_d = cnt_d + CW'(1);
      end
    end
    empty_d = (cnt_d == '0);
  end

  // State registers; the ROM has no reset, but buffered entries do so the head reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  assign head  = mem_q[0];
  assign empty = empty_q;
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(BUF_DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the synchronous ROM, tags returned words with
// their PC, buffers them and hands them to decode on valid/ready.
// Issue is credit-based on registered state only (FIFO count + in-flight),
// so out_ready never has a combinational path to rom_addr.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = IF_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH    = IF_DATA_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(CORE_RESET_PC),
  parameter int                       BUF_DEPTH     = IF_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-3:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_q,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = ADDRESS_WIDTH + DATA_WIDTH;

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic                     issue, push, pop;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_full, fifo_empty;
  logic [EW-1:0]            fifo_head;

  // Issue/return/redirect decisions; redirect suppresses issue and discards the in-flight word.
  always_comb begin
    issue         = !redirect_valid && ((int'(fifo_count) + int'(inflight_q)) < BUF_DEPTH);
    push          = inflight_q && !redirect_valid;
    pop           = !fifo_empty && out_ready;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDRESS_WIDTH'(3);
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDRESS_WIDTH'(4);
      inflight_pc_d = fetch_pc_q;
    end
  end

  // PC and in-flight tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH    (EW),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(redirect_valid),
    .push (push),
    .pop  (pop),
    .din  ({inflight_pc_q, rom_q}),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign rom_addr              = fetch_pc_q[ADDRESS_WIDTH-1:2];
  assign out_valid             = !fifo_empty;
  assign {out_pc, out_instr}   = fifo_head;

  // The issue credit rule must make a push into a full, non-draining FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a word[i]=i ROM model and an
// expected-stream scoreboard that is reloaded on every reset/redirect.
module tb_instr_fetch;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-3:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  instr_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_q         (rom_q),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model, word[i] = i, no reset.
  always @(posedge clk) rom_q <= DW'(rom_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stream from a start PC, wrapping at 2**AW.
  task automatic load(input logic [AW-1:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      exp_t e;
      e.pc    = start + AW'(4 * i);
      e.instr = DW'(e.pc >> 2);
      sb.push_back(e);
    end
  endtask

  // One cycle: drive inputs after the edge, then score any handshake of this cycle.
  task automatic cyc(input logic rdy, input logic rv = 1'b0, input logic [AW-1:0] rpc = '0);
    @(posedge clk);
    #1;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL sb_underflow: observed pc %0h expected no handshake", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hs_pc", 64'(out_pc), 64'(e.pc));
        chk("hs_instr", 64'(out_instr), 64'(e.instr));
      end
    end
    if (rv) load(rpc & ~AW'(3));
  endtask

  initial begin
    logic [AW-1:0] held_pc;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    reset          = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    repeat (2) @(posedge clk);

    // 1: release reset between edges; first valid in cycle 2, then one word per cycle.
    @(posedge clk);
    #2;
    load('0);
    out_ready = 1'b1;
    reset     = 1'b0;
    #1 chk("lat_c0", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("lat_c1", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("lat_c2", 64'(out_valid), 64'd1);
    repeat (6) begin cyc(1'b1); chk("stream_valid", 64'(out_valid), 64'd1); end

    // 2: backpressure for 5 cycles; head holds and fetch stalls BD words ahead.
    held_pc = sb[0].pc;
    repeat (5) begin
      cyc(1'b0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_pc", 64'(out_pc), 64'(held_pc));
    end
    chk("bp_rom_addr", 64'(rom_addr), 64'((held_pc + AW'(4 * BD)) >> 2));
    repeat (8) begin cyc(1'b1); chk("rel_valid", 64'(out_valid), 64'd1); end

    // 3: build 2 buffered + 1 in flight, then redirect to 0x100.
    cyc(1'b0);
    cyc(1'b0, 1'b1, AW'('h100));
    cyc(1'b1); chk("rd_c1", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("rd_c2", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("rd_c3", 64'(out_valid), 64'd1);
    chk("rd_tgt_pc", 64'(out_pc), 64'h100);
    cyc(1'b1);

    // 4: redirect in the same cycle as the handshake of PC 0x8.
    cyc(1'b1, 1'b1, '0);
    repeat (4) cyc(1'b1);
    cyc(1'b1, 1'b1, AW'('h200));
    chk("hsr_pc", 64'(out_pc), 64'h8);
    cyc(1'b1); chk("hsr_c1", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("hsr_c2", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("hsr_tgt", 64'(out_pc), 64'h200);

    // 5: wrap-around at the top of the address space; low bits of redirect_pc ignored.
    cyc(1'b1, 1'b1, AW'('h3FFE));
    repeat (2) cyc(1'b1);
    cyc(1'b1); chk("wrap_top", 64'(out_pc), 64'h3FFC);
    cyc(1'b1); chk("wrap_zero", 64'(out_pc), 64'h0);
    cyc(1'b1); chk("wrap_next", 64'(out_pc), 64'h4);
    repeat (3) cyc(1'b1);

    // 6: async reset pulse between edges, then restart at RESET_PC.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_pc", 64'(out_pc), 64'd0);
    @(posedge clk);
    #2;
    load('0);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    reset          = 1'b0;
    #1 chk("rst2_c0", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("rst2_c1", 64'(out_valid), 64'd0);
    cyc(1'b1); chk("rst2_c2", 64'(out_valid), 64'd1);
    repeat (3) cyc(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
